// File: rtl/fpga_conf_spi_pkg.sv
// -----------------------------------------------------------------------------
// fpga_conf_pkg
//   Shared definitions for the SPI configuration receiver: command encodings,
//   receiver FSM states and the fixed register indices.
// -----------------------------------------------------------------------------
package fpga_conf_pkg;

    // Command field encodings (frame MSBs)
    localparam int unsigned CMD_SET_CONFREG = 1;
    localparam int unsigned CMD_SET_DIVISOR = 2;
    localparam int unsigned CMD_WRITE       = 3;
    localparam int unsigned CMD_READ        = 4;
    localparam int unsigned CMD_CLEAR_ERR   = 5;

    // Fixed register slots
    localparam int unsigned REG_CONF = 0;   // mode/conf word, commit-gated
    localparam int unsigned REG_DIV  = 1;   // divisor

    // Receiver FSM
    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,    // wait for ncs high after reset
        ST_IDLE      = 2'd1,    // between frames
        ST_SHIFT     = 2'd2,    // frame in progress
        ST_DECODE    = 2'd3     // one-cycle frame decode
    } state_e;

endpackage

// File: rtl/fpga_conf_spi_if.sv
// -----------------------------------------------------------------------------
// fpga_conf_spi_if
//   SPI pin bundle between the ARM (master) and the configuration receiver
//   (slave).
//   spck : SPI clock, driven by master
//   mosi : data master -> slave, MSB first
//   ncs  : chip select, active low
//   miso : readback data slave -> master
// -----------------------------------------------------------------------------
interface fpga_conf_spi_if;
    logic spck;
    logic mosi;
    logic ncs;
    logic miso;

    modport master (output spck, output mosi, output ncs, input  miso);
    modport slave  (input  spck, input  mosi, input  ncs, output miso);
endinterface

// File: rtl/fpga_conf_spi_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
//   Two-flop synchroniser for an asynchronous pin plus a third flop for edge
//   detection. An edge at the pin before clk edge k is visible on rise_o /
//   fall_o after edge k+1, so logic registering it acts at edge k+2.
//   clk    : sampling clock
//   rst    : synchronous active-high reset (all flops to 0)
//   d_i    : asynchronous input
//   s_o    : synchronised level
//   rise_o : one-cycle pulse on a synchronised 0->1
//   fall_o : one-cycle pulse on a synchronised 1->0
// -----------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // NOTE: non-blocking assignments make every flop sample the pre-edge value
    // of its neighbour, which is what turns these three into a shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign s_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/fpga_conf_spi.sv
// -----------------------------------------------------------------------------
// fpga_conf_spi
//   SPI configuration receiver. Oversamples the ARM SPI pins in the pck0
//   domain, decodes fixed-length frames {cmd, addr, data} into a bank of
//   NUM_REGS registers, and reads registers back on miso in the frame after a
//   READ. Register 0 is held in a shadow until safe_i opens a commit window so
//   mode changes land at a glitch-free point.
//   pck0           : system clock (spck must be <= pck0/4)
//   rst            : synchronous active-high reset
//   spi            : SPI pins (slave side)
//   safe_i         : commit-window strobe for register 0
//   conf_o         : committed register 0
//   regs_o         : all registers flattened, slot 0 = committed conf
//   conf_pending_o : register 0 shadow waiting for safe_i
//   wr_stb_o       : one-cycle pulse on each accepted register write
//   wr_addr_o      : address of the last accepted write
//   frame_err_o    : sticky bad-length / bad-address flag
// -----------------------------------------------------------------------------
module fpga_conf_spi
    import fpga_conf_pkg::*;
#(
    parameter int CMD_W    = 4,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic                       pck0,
    input  logic                       rst,
    fpga_conf_spi_if.slave             spi,
    input  logic                       safe_i,
    output logic [DATA_W-1:0]          conf_o,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       conf_pending_o,
    output logic                       wr_stb_o,
    output logic [ADDR_W-1:0]          wr_addr_o,
    output logic                       frame_err_o
);

    localparam int FRAME_W = CMD_W + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    // -------------------------------------------------------------------------
    // Pin synchronisers
    // -------------------------------------------------------------------------
    logic spck_s, spck_rise, spck_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic ncs_s,  ncs_rise,  ncs_fall;

    sync_edge u_sync_spck (
        .clk    (pck0),
        .rst    (rst),
        .d_i    (spi.spck),
        .s_o    (spck_s),
        .rise_o (spck_rise),
        .fall_o (spck_fall)
    );

    sync_edge u_sync_mosi (
        .clk    (pck0),
        .rst    (rst),
        .d_i    (spi.mosi),
        .s_o    (mosi_s),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    sync_edge u_sync_ncs (
        .clk    (pck0),
        .rst    (rst),
        .d_i    (spi.ncs),
        .s_o    (ncs_s),
        .rise_o (ncs_rise),
        .fall_o (ncs_fall)
    );

    // Only the level of mosi and the edges of spck are meaningful.
    logic unused_sync;
    assign unused_sync = ^{mosi_rise, mosi_fall, spck_s};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e state_q, state_d;

    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [FRAME_W-1:0] rx_q,      rx_d;
    logic [DATA_W-1:0]  shadow_q,  shadow_d;
    logic               pending_q, pending_d;
    logic [DATA_W-1:0]  conf_q,    conf_d;
    logic [DATA_W-1:0]  tx_q,      tx_d;
    logic               miso_q,    miso_d;
    logic               wr_stb_q,  wr_stb_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic               err_q,     err_d;

    // Slot 0 lives in conf_q/shadow_q, so the plain bank starts at 1.
    logic [DATA_W-1:0]  regs_q [1:NUM_REGS-1];
    logic [DATA_W-1:0]  regs_d [1:NUM_REGS-1];

    // Frame fields
    logic [CMD_W-1:0]   cmd;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic               addr_ok;
    logic               is_conf_wr;

    assign cmd     = rx_q[FRAME_W-1 -: CMD_W];
    assign addr    = rx_q[DATA_W +: ADDR_W];
    assign data    = rx_q[DATA_W-1:0];
    assign addr_ok = ({1'b0, addr} < NUM_REGS_L);

    assign is_conf_wr = (cmd == CMD_W'(CMD_SET_CONFREG)) ||
                        ((cmd == CMD_W'(CMD_WRITE)) && (addr == ADDR_W'(REG_CONF)));

    // Externally visible register view: slot 0 is the committed conf word.
    logic [DATA_W-1:0]  reg_view [NUM_REGS];
    logic [DATA_W-1:0]  rd_data;

    always_comb begin
        reg_view[0] = conf_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            reg_view[i] = regs_q[i];
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                rd_data = reg_view[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge pck0) begin
        if (rst) begin
            state_q <= ST_WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            // A frame already running at reset release is skipped by waiting
            // for chip select to go idle first.
            ST_WAIT_IDLE: if (ncs_s)    state_d = ST_IDLE;
            ST_IDLE:      if (ncs_fall) state_d = ST_SHIFT;
            ST_SHIFT:     if (ncs_rise) state_d = ST_DECODE;
            ST_DECODE:                  state_d = ST_IDLE;
            default:                    state_d = ST_WAIT_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs / datapath
    // -------------------------------------------------------------------------
    // NOTE: every _d gets its hold value before any branch; a path that leaves
    // one unassigned would infer a latch instead of a mux.
    always_comb begin
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        conf_d    = conf_q;
        regs_d    = regs_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        err_d     = err_q;

        // Commit window. Evaluated before decode so a reg0 write landing in
        // the same cycle re-arms pending with the new shadow value.
        if (pending_q && safe_i) begin
            conf_d    = shadow_q;
            pending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    cnt_d  = '0;
                    rx_d   = '0;
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = tx_q << 1;
                end
            end

            ST_SHIFT: begin
                if (spck_rise) begin
                    rx_d = {rx_q[FRAME_W-2:0], mosi_s};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (spck_fall) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = tx_q << 1;
                end
                // Readback data is valid for one frame only.
                if (ncs_rise) begin
                    tx_d = '0;
                end
            end

            ST_DECODE: begin
                if (cnt_q != CNT_FULL) begin
                    err_d = 1'b1;
                end else if (is_conf_wr) begin
                    shadow_d  = data;
                    pending_d = 1'b1;
                    wr_stb_d  = 1'b1;
                    wr_addr_d = ADDR_W'(REG_CONF);
                end else if (cmd == CMD_W'(CMD_SET_DIVISOR)) begin
                    regs_d[REG_DIV] = data;
                    wr_stb_d        = 1'b1;
                    wr_addr_d       = ADDR_W'(REG_DIV);
                end else if (cmd == CMD_W'(CMD_WRITE)) begin
                    if (addr_ok) begin
                        for (int i = 1; i < NUM_REGS; i++) begin
                            if (addr == ADDR_W'(i)) begin
                                regs_d[i] = data;
                            end
                        end
                        wr_stb_d  = 1'b1;
                        wr_addr_d = addr;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cmd == CMD_W'(CMD_READ)) begin
                    if (addr_ok) begin
                        tx_d = rd_data;
                    end else begin
                        tx_d  = '0;
                        err_d = 1'b1;
                    end
                end else if (cmd == CMD_W'(CMD_CLEAR_ERR)) begin
                    err_d = 1'b0;
                end
            end

            default: ;
        endcase

        // miso is quiet whenever the slave is deselected.
        if (ncs_s) begin
            miso_d = 1'b0;
        end
    end

    // NOTE: the register bank is reset along with the rest so the mode muxes
    // downstream see a defined all-zero configuration out of reset.
    always_ff @(posedge pck0) begin
        if (rst) begin
            cnt_q     <= '0;
            rx_q      <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            conf_q    <= '0;
            regs_q    <= '{default: '0};
            tx_q      <= '0;
            miso_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            conf_q    <= conf_d;
            regs_q    <= regs_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            err_q     <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[i*DATA_W +: DATA_W] = reg_view[i];
        end
    end

    assign spi.miso       = miso_q;
    assign conf_o         = conf_q;
    assign conf_pending_o = pending_q;
    assign wr_stb_o       = wr_stb_q;
    assign wr_addr_o      = wr_addr_q;
    assign frame_err_o    = err_q;

endmodule

// File: tb/tb_fpga_conf_spi.sv
// -----------------------------------------------------------------------------
// tb_fpga_conf_spi
//   Directed bench for fpga_conf_spi with default parameters (16-bit frames,
//   4 registers). Expected register writes and expected miso bits are queued
//   as frames are sent; two monitor processes pop and compare them when the
//   DUT strobes a write or the master clocks a bit in.
// -----------------------------------------------------------------------------
module tb_fpga_conf_spi;

    logic        pck0;
    logic        rst;
    logic        safe_i;
    logic [7:0]  conf_o;
    logic [31:0] regs_o;
    logic        conf_pending_o;
    logic        wr_stb_o;
    logic [3:0]  wr_addr_o;
    logic        frame_err_o;

    fpga_conf_spi_if spi_if ();

    fpga_conf_spi dut (
        .pck0           (pck0),
        .rst            (rst),
        .spi            (spi_if),
        .safe_i         (safe_i),
        .conf_o         (conf_o),
        .regs_o         (regs_o),
        .conf_pending_o (conf_pending_o),
        .wr_stb_o       (wr_stb_o),
        .wr_addr_o      (wr_addr_o),
        .frame_err_o    (frame_err_o)
    );

    initial pck0 = 1'b0;
    always #5 pck0 = ~pck0;

    int cyc = 0;
    always @(posedge pck0) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_exp_t;

    wr_exp_t wr_q [$];
    logic    miso_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge pck0);
    endtask

    // One SPI frame, MSB first, spck = pck0/8. exp_tx is the byte expected on
    // miso during this frame (zeros after it). A write expectation is queued
    // with the cycle on which the strobe must be seen.
    task automatic send_frame(input logic [31:0] bits, input int n, input logic [7:0] exp_tx,
                              input bit exp_wr, input logic [3:0] wa, input logic [7:0] wd);
        wr_exp_t e;
        spi_if.ncs = 1'b0;
        wait_cyc(4);
        for (int i = n - 1; i >= 0; i--) begin
            int j;
            j = n - 1 - i;
            spi_if.mosi = bits[i];
            miso_q.push_back((j < 8) ? exp_tx[7 - j] : 1'b0);
            wait_cyc(4);
            spi_if.spck = 1'b1;
            wait_cyc(4);
            spi_if.spck = 1'b0;
        end
        wait_cyc(4);
        spi_if.ncs = 1'b1;
        if (exp_wr) begin
            e.addr = wa;
            e.data = wd;
            e.cyc  = cyc + 4;
            wr_q.push_back(e);
        end
        wait_cyc(8);
    endtask

    task automatic pulse_safe();
        safe_i = 1'b1;
        wait_cyc(1);
        safe_i = 1'b0;
    endtask

    // Write monitor
    always @(negedge pck0) begin
        if (!rst && wr_stb_o) begin
            if (wr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_wr: got addr %0h, expected no write (t=%0t)", wr_addr_o, $time);
            end else begin
                wr_exp_t e;
                e = wr_q.pop_front();
                check("wr_addr", 32'(wr_addr_o), 32'(e.addr));
                check("wr_cycle", cyc, e.cyc);
                if (e.addr == 4'd0) begin
                    check("wr_pending", 32'(conf_pending_o), 32'd1);
                end else begin
                    check("wr_data", 32'(regs_o[int'(e.addr) * 8 +: 8]), 32'(e.data));
                end
            end
        end
    end

    // miso monitor: value presented at each master spck rise
    always @(posedge spi_if.spck) begin
        if (miso_q.size() > 0) begin
            logic b;
            b = miso_q.pop_front();
            check("miso_bit", 32'(spi_if.miso), 32'(b));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        safe_i      = 1'b0;
        spi_if.ncs  = 1'b1;
        spi_if.spck = 1'b0;
        spi_if.mosi = 1'b0;
        repeat (5) @(negedge pck0);
        rst = 1'b0;
        wait_cyc(4);

        // Reset state
        check("rst_conf",    32'(conf_o), 32'h0);
        check("rst_regs",    regs_o, 32'h0);
        check("rst_pending", 32'(conf_pending_o), 32'h0);
        check("rst_err",     32'(frame_err_o), 32'h0);
        check("rst_stb",     32'(wr_stb_o), 32'h0);
        check("rst_waddr",   32'(wr_addr_o), 32'h0);
        check("rst_miso",    32'(spi_if.miso), 32'h0);

        // SET_DIVISOR
        send_frame(32'h205A, 16, 8'h00, 1'b1, 4'h1, 8'h5A);
        check("div_regs",  regs_o, 32'h0000_5A00);
        check("div_waddr", 32'(wr_addr_o), 32'h1);

        // SET_CONFREG held off until safe_i
        send_frame(32'h1021, 16, 8'h00, 1'b1, 4'h0, 8'h21);
        check("conf_pend",   32'(conf_pending_o), 32'h1);
        check("conf_hold",   32'(conf_o), 32'h0);
        wait_cyc(3);
        check("conf_hold2",  32'(conf_o), 32'h0);
        pulse_safe();
        check("conf_commit", 32'(conf_o), 32'h21);
        check("conf_clr",    32'(conf_pending_o), 32'h0);
        check("conf_regs",   regs_o, 32'h0000_5A21);

        // Two reg0 writes before a single commit
        send_frame(32'h1021, 16, 8'h00, 1'b1, 4'h0, 8'h21);
        send_frame(32'h3022, 16, 8'h00, 1'b1, 4'h0, 8'h22);
        check("dbl_pend",   32'(conf_pending_o), 32'h1);
        check("dbl_hold",   32'(conf_o), 32'h21);
        pulse_safe();
        check("dbl_commit", 32'(conf_o), 32'h22);
        check("dbl_clr",    32'(conf_pending_o), 32'h0);
        pulse_safe();
        check("dbl_once",   32'(conf_o), 32'h22);

        // Length errors
        send_frame(32'h2077, 15, 8'h00, 1'b0, 4'h0, 8'h00);
        check("short_err",  32'(frame_err_o), 32'h1);
        check("short_regs", regs_o, 32'h0000_5A22);
        send_frame(32'h5000, 16, 8'h00, 1'b0, 4'h0, 8'h00);
        check("clr_err1",   32'(frame_err_o), 32'h0);
        send_frame(32'h12077, 17, 8'h00, 1'b0, 4'h0, 8'h00);
        check("long_err",   32'(frame_err_o), 32'h1);
        check("long_regs",  regs_o, 32'h0000_5A22);
        check("long_pend",  32'(conf_pending_o), 32'h0);
        send_frame(32'h5000, 16, 8'h00, 1'b0, 4'h0, 8'h00);
        check("clr_err2",   32'(frame_err_o), 32'h0);

        // Out-of-range write
        send_frame(32'h3511, 16, 8'h00, 1'b0, 4'h0, 8'h00);
        check("badw_err",   32'(frame_err_o), 32'h1);
        check("badw_regs",  regs_o, 32'h0000_5A22);
        send_frame(32'h5000, 16, 8'h00, 1'b0, 4'h0, 8'h00);

        // Write reg3 then read it back
        send_frame(32'h33C3, 16, 8'h00, 1'b1, 4'h3, 8'hC3);
        check("w3_regs",    regs_o, 32'hC300_5A22);
        send_frame(32'h4300, 16, 8'h00, 1'b0, 4'h0, 8'h00);
        check("rd_err",     32'(frame_err_o), 32'h0);
        check("miso_idle",  32'(spi_if.miso), 32'h0);
        send_frame(32'h0000, 16, 8'hC3, 1'b0, 4'h0, 8'h00);
        send_frame(32'h0000, 16, 8'h00, 1'b0, 4'h0, 8'h00);

        // Out-of-range read
        send_frame(32'h4700, 16, 8'h00, 1'b0, 4'h0, 8'h00);
        check("badr_err",   32'(frame_err_o), 32'h1);
        send_frame(32'h0000, 16, 8'h00, 1'b0, 4'h0, 8'h00);
        send_frame(32'h5000, 16, 8'h00, 1'b0, 4'h0, 8'h00);

        // Reset in the middle of a frame with a pending reg0 write
        send_frame(32'h1077, 16, 8'h00, 1'b1, 4'h0, 8'h77);
        check("mid_pend0",  32'(conf_pending_o), 32'h1);
        spi_if.ncs = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < 16; i++) begin
            spi_if.mosi = 1'b1;
            wait_cyc(4);
            spi_if.spck = 1'b1;
            wait_cyc(4);
            spi_if.spck = 1'b0;
            if (i == 4) begin
                rst = 1'b1;
                wait_cyc(3);
                rst = 1'b0;
                wait_cyc(2);
                check("mid_conf",  32'(conf_o), 32'h0);
                check("mid_regs",  regs_o, 32'h0);
                check("mid_pend",  32'(conf_pending_o), 32'h0);
                check("mid_err",   32'(frame_err_o), 32'h0);
                check("mid_waddr", 32'(wr_addr_o), 32'h0);
            end
        end
        wait_cyc(4);
        spi_if.ncs = 1'b1;
        wait_cyc(8);
        check("post_regs", regs_o, 32'h0);
        check("post_err",  32'(frame_err_o), 32'h0);
        check("post_pend", 32'(conf_pending_o), 32'h0);
        check("post_conf", 32'(conf_o), 32'h0);
        pulse_safe();
        check("post_safe", 32'(conf_o), 32'h0);

        send_frame(32'h2011, 16, 8'h00, 1'b1, 4'h1, 8'h11);
        check("recov_regs", regs_o, 32'h0000_1100);

        wait_cyc(20);
        while (wr_q.size() > 0) begin
            wr_exp_t e;
            e = wr_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_wr: got no strobe, expected addr %0h data %0h", e.addr, e.data);
        end
        while (miso_q.size() > 0) begin
            void'(miso_q.pop_front());
            n_vec++;
            n_err++;
            $display("FAIL missing_miso: got no spck rise, expected a sampled bit");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpga_conf_spi.md
Name: fpga_conf_spi

Overview:
Parametrised successor to the top-level SPI configuration receiver. It oversamples the ARM's SPI pins (spck/mosi/ncs) in the pck0 domain and decodes fixed-length frames into a bank of NUM_REGS configuration registers. Register 0 (the mode/conf word) is committed only on a caller-supplied safe strobe, so mode switches cannot glitch the carrier. It adds register readback on miso, frame-length checking and a sticky error flag. Its outputs feed the major-mode muxes and sub-mode selects.

Parameters:
CMD_W, 4, command field width (frame MSBs)
ADDR_W, 4, register address field width
DATA_W, 8, register/data field width
NUM_REGS, 4, register count; 2..2**ADDR_W; reg0=conf word, reg1=divisor
FRAME_W, CMD_W+ADDR_W+DATA_W (derived localparam, not overridable), bits per frame

Ports:
pck0  in  1  system clock; requires spck <= pck0/4
rst  in  1  synchronous, active-high reset
spck  in  1  SPI clock, async; mosi sampled on its rising edge
mosi  in  1  SPI data in, MSB first
ncs  in  1  SPI chip select, active low, async
miso  out  1  readback data, registered
safe_i  in  1  commit-window strobe for reg0 (e.g. carrier phase point)
conf_o  out  DATA_W  committed reg0
regs_o  out  NUM_REGS*DATA_W  flattened registers; reg0 slot carries committed value
conf_pending_o  out  1  reg0 shadow awaiting commit
wr_stb_o  out  1  one-cycle pulse on any accepted register write
wr_addr_o  out  ADDR_W  address of last accepted write
frame_err_o  out  1  sticky bad-length / bad-address flag

Behaviour:
- Reset: all registers, shadow, conf_o, regs_o, pending, wr_stb_o, wr_addr_o, frame_err_o, miso and bit counter go to 0. State goes to WAIT_IDLE.
- Sync: spck, mosi and ncs each pass through 2 flops. A third flop per signal gives edge detection. An edge present at the pin before pck0 edge k is detected at edge k+2.
- FSM:
  - WAIT_IDLE -> IDLE when ncs_s=1. A frame already in progress at reset release is therefore ignored.
  - IDLE -> SHIFT on ncs fall; bit counter cleared, rx shift cleared.
  - SHIFT: on each spck rise, rx <= {rx, mosi_s} and count++. Count saturates at FRAME_W+1.
  - SHIFT -> DECODE on ncs rise.
  - DECODE (1 cycle) -> IDLE.
- Decode happens only if count==FRAME_W; otherwise frame_err_o=1 and no other effect. cmd=rx[FRAME_W-1 -: CMD_W], addr=next ADDR_W bits, data=low DATA_W bits.
  - 0001 SET_CONFREG: shadow<=data, pending<=1.
  - 0010 SET_DIVISOR: reg1<=data.
  - 0011 WRITE: addr==0 behaves as SET_CONFREG; addr<NUM_REGS writes that register; addr>=NUM_REGS sets frame_err_o.
  - 0100 READ: tx<=reg[addr] (reg0 returns committed value); addr>=NUM_REGS sets error and tx<=0.
  - 0101 CLEAR_ERR: frame_err_o<=0.
  - All other commands: ignored, no error.
- Latency: register and wr_stb_o/wr_addr_o update at the DECODE edge, 3 pck0 cycles after ncs rise is first sampled. wr_stb_o fires for writes to reg0 as well as other registers.
- Commit: on any cycle with pending=1 and safe_i=1, conf_o<=shadow and pending<=0.
  - safe_i in the DECODE cycle does not commit the write being decoded; it commits on the next safe_i.
  - A second reg0 write before commit overwrites the shadow; only one commit occurs.
- miso:
  - 0 while ncs_s=1.
  - In the frame following a READ: at ncs fall miso<=tx[DATA_W-1], then shifts on each synchronized spck fall, zero-filled.
  - tx clears at the end of that frame; frames without a preceding READ return zeros.
  - A READ frame itself shifts out whatever tx holds at that time.
- Reset mid-frame drops the frame, clears pending without committing, and returns to WAIT_IDLE.

Decomposition:
- Package fpga_conf_pkg holds the command encodings (CMD_SET_CONFREG=1, CMD_SET_DIVISOR=2, CMD_WRITE=3, CMD_READ=4, CMD_CLEAR_ERR=5), the FSM state enum, and the reg index constants REG_CONF=0, REG_DIV=1.
- One sub-module, sync_edge: 2-flop synchroniser plus rise/fall detect, instantiated 3x.

Test Plan:
- Reset, then frame 0x2_0_5A (SET_DIVISOR) -> regs_o reg1=0x5A 3 cycles after ncs rise; wr_stb_o pulses once with wr_addr_o=1.
- Frame 0x1_0_21, safe_i held 0 -> conf_pending_o=1 and conf_o=0. Pulse safe_i -> conf_o=0x21 next edge, pending=0.
- Two reg0 writes (0x21 then 0x22) before safe_i -> a single commit with conf_o=0x22.
- 15-bit frame, then 17-bit frame -> frame_err_o=1 and no register change. CLEAR_ERR frame 0x5000 -> frame_err_o=0.
- Write reg3=0xC3 (0x3_3_C3), READ reg3 (0x4_3_00), then dummy frame -> miso presents 1,1,0,0,0,0,1,1 on the first 8 spck rises.
- Assert rst with ncs low mid-frame and keep ncs low after release -> no decode until ncs goes high and starts a new frame; all outputs 0.
